// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word link (transmitter and receiver).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serial_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Clock cycles occupied by one complete frame on the line.
  function automatic int unsigned frame_cycles(input int unsigned width,
                                               input int unsigned bit_cycles,
                                               input int unsigned stop_bits);
    return (1 + width + stop_bits) * bit_cycles;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: pulses bit_tick on the last cycle of each serial bit while run is high.
module serial_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] count;

  assign bit_tick = run && (count == CW'(BIT_CYCLES - 1));

  // Holding at zero while idle aligns the first bit of a frame to the cycle after accept.
  always_ff @(posedge clock) begin
    if (reset_ || !run || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// UART-style word transmitter: start bit, WIDTH data bits MSB-first, STOP_BITS stop bits.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  serial_state_t    state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shifted;
  logic [IW-1:0]    bit_idx;
  logic [SW-1:0]    stop_cnt;
  logic             run;
  logic             bit_tick;
  logic             accept;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid & in_ready;
  assign run      = (state != IDLE);
  assign shifted  = shift << 1;

  serial_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clock    (clock),
    .reset_   (reset_),
    .run      (run),
    .bit_tick (bit_tick)
  );

  // tx is loaded one bit ahead so the line changes exactly on bit boundaries from a flop.
  always_ff @(posedge clock) begin
    if (reset_) begin
      state    <= IDLE;
      tx       <= LINE_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            tx       <= START_BIT;
            shift    <= in_data;
            bit_idx  <= '0;
            stop_cnt <= '0;
          end
        end
        START: begin
          if (bit_tick) begin
            state <= DATA;
            tx    <= shift[WIDTH-1];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == IW'(WIDTH - 1)) begin
              state   <= STOP;
              tx      <= LINE_IDLE;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + IW'(1);
              shift   <= shifted;
              tx      <= shifted[WIDTH-1];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop_cnt == SW'(STOP_BITS - 1)) begin
              state    <= IDLE;
              stop_cnt <= '0;
            end else begin
              stop_cnt <= stop_cnt + SW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: three instances (baseline, one cycle per bit, two stop bits).
module tb_serial_word_tx;

  logic        clock = 1'b0;
  logic        reset_;
  logic        in_valid_v [3];
  logic [15:0] in_data_v  [3];
  logic        ready_v    [3];
  logic        tx_v       [3];
  logic        busy_v     [3];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [15:0] rx_q [$];
  logic [15:0] exp_q [$];
  int          rx_err = 0;

  always #5 clock = ~clock;

  serial_word_tx #(.WIDTH(16), .BIT_CYCLES(4), .STOP_BITS(1)) u_dut0 (
    .clock(clock), .reset_(reset_), .in_valid(in_valid_v[0]), .in_data(in_data_v[0]),
    .in_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));

  serial_word_tx #(.WIDTH(16), .BIT_CYCLES(1), .STOP_BITS(1)) u_dut1 (
    .clock(clock), .reset_(reset_), .in_valid(in_valid_v[1]), .in_data(in_data_v[1]),
    .in_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));

  serial_word_tx #(.WIDTH(16), .BIT_CYCLES(4), .STOP_BITS(2)) u_dut2 (
    .clock(clock), .reset_(reset_), .in_valid(in_valid_v[2]), .in_data(in_data_v[2]),
    .in_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected line level on cycle c (1-based) after accept.
  function automatic logic exp_tx(input logic [15:0] w, input int c, input int bc);
    int p;
    p = (c - 1) / bc;
    if (p == 0) return 1'b0;
    if (p <= 16) return w[16-p];
    return 1'b1;
  endfunction

  task automatic accept(input int idx, input logic [15:0] w, input bit hold);
    int n;
    n = 0;
    in_valid_v[idx] = 1'b1;
    in_data_v[idx]  = w;
    while (!ready_v[idx] && n < 200) begin
      tick();
      n++;
    end
    if (!ready_v[idx]) check("accept_timeout", 32'd0, 32'd1);
    tick();
    if (!hold) in_valid_v[idx] = 1'b0;
  endtask

  task automatic frame_check(input int idx, input logic [15:0] w, input int bc, input int sb,
                             input int chg_c, input logic [15:0] chg_d, input string tag,
                             output int max_low);
    int f;
    int run;
    logic e;
    f = (1 + 16 + sb) * bc;
    run = 0;
    max_low = 0;
    for (int c = 1; c <= f; c++) begin
      e = exp_tx(w, c, bc);
      check($sformatf("%s_tx_c%0d", tag, c), 32'(tx_v[idx]), 32'(e));
      check($sformatf("%s_ready_c%0d", tag, c), 32'(ready_v[idx]), 32'd0);
      if (tx_v[idx] == 1'b0) begin
        run++;
        if (run > max_low) max_low = run;
      end else begin
        run = 0;
      end
      if (c == chg_c) in_data_v[idx] = chg_d;
      if (c < f) tick();
    end
    tick();
    check($sformatf("%s_ready_end", tag), 32'(ready_v[idx]), 32'd1);
    check($sformatf("%s_busy_end", tag), 32'(busy_v[idx]), 32'd0);
    check($sformatf("%s_tx_end", tag), 32'(tx_v[idx]), 32'd1);
  endtask

  task automatic idle_watch(input int idx, input int n, input string tag);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_v[idx] !== 1'b1 || ready_v[idx] !== 1'b1) lows++;
      tick();
    end
    check(tag, 32'(lows), 32'd0);
  endtask

  // Behavioral receiver on the one-cycle-per-bit instance.
  initial begin
    bit          active;
    int          nb;
    logic [15:0] acc;
    active = 1'b0;
    nb = 0;
    acc = '0;
    forever begin
      @(negedge clock);
      if (reset_ !== 1'b0) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx_v[1] === 1'b0) begin
          active = 1'b1;
          nb = 0;
        end
      end else if (nb < 16) begin
        acc = {acc[14:0], tx_v[1]};
        nb++;
      end else begin
        if (tx_v[1] !== 1'b1) rx_err++;
        rx_q.push_back(acc);
        active = 1'b0;
      end
    end
  end

  initial begin
    int          ml;
    int          q0;
    int          mism;
    logic [15:0] w;

    reset_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0;
      in_data_v[i]  = '0;
    end
    repeat (2) tick();
    reset_ = 1'b0;
    check("rst_tx", 32'(tx_v[0]), 32'd1);
    check("rst_ready", 32'(ready_v[0]), 32'd1);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    idle_watch(0, 20, "rst_idle");

    accept(0, 16'hA5C3, 1'b0);
    frame_check(0, 16'hA5C3, 4, 1, 0, 16'h0, "a5c3", ml);

    // Back-to-back with data changing mid-frame.
    accept(0, 16'h1234, 1'b1);
    frame_check(0, 16'h1234, 4, 1, 30, 16'hBEEF, "b2b1", ml);
    tick();
    in_valid_v[0] = 1'b0;
    frame_check(0, 16'hBEEF, 4, 1, 0, 16'h0, "b2b2", ml);

    // Reset abandons a frame at cycle 30.
    accept(0, 16'h0F0F, 1'b0);
    repeat (29) tick();
    reset_ = 1'b1;
    tick();
    reset_ = 1'b0;
    check("midrst_tx", 32'(tx_v[0]), 32'd1);
    check("midrst_ready", 32'(ready_v[0]), 32'd1);
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    idle_watch(0, 20, "midrst_idle");
    accept(0, 16'h0001, 1'b0);
    frame_check(0, 16'h0001, 4, 1, 0, 16'h0, "post_rst", ml);

    accept(0, 16'h0000, 1'b0);
    frame_check(0, 16'h0000, 4, 1, 0, 16'h0, "zeros", ml);
    check("zeros_low_run", 32'(ml), 32'd68);
    accept(0, 16'hFFFF, 1'b0);
    frame_check(0, 16'hFFFF, 4, 1, 0, 16'h0, "ones", ml);
    check("ones_low_run", 32'(ml), 32'd4);

    accept(1, 16'h8001, 1'b0);
    frame_check(1, 16'h8001, 1, 1, 0, 16'h0, "bc1", ml);
    accept(2, 16'h5A5A, 1'b0);
    frame_check(2, 16'h5A5A, 4, 2, 0, 16'h0, "sb2", ml);

    // Reset wins over a same-cycle handshake.
    repeat (3) tick();
    q0 = rx_q.size();
    reset_ = 1'b1;
    in_valid_v[1] = 1'b1;
    in_data_v[1]  = 16'h0F0F;
    tick();
    reset_ = 1'b0;
    in_valid_v[1] = 1'b0;
    check("rst_hs_ready", 32'(ready_v[1]), 32'd1);
    check("rst_hs_tx", 32'(tx_v[1]), 32'd1);
    idle_watch(1, 20, "rst_hs_idle");
    check("rst_hs_rx_count", 32'(rx_q.size()), 32'(q0));

    rx_q.delete();
    rx_err = 0;
    for (int i = 0; i < 1000; i++) begin
      w = 16'($urandom_range(0, 65535));
      exp_q.push_back(w);
      accept(1, w, 1'b0);
    end
    repeat (30) tick();
    check("loop_count", 32'(rx_q.size()), 32'd1000);
    mism = rx_err;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) mism++;
    end
    check("loop_mismatches", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
